// File: rtl/vga_clk_pkg.sv
// Shared types and defaults for the VGA pixel-PLL power-up/recovery sequencer.
package vga_clk_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } vga_clk_state_t;

    localparam int unsigned DEF_PLL_RESET_CYCLES    = 12;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1200;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 120000;
    localparam int unsigned DEF_MAX_RETRIES         = 3;

    localparam int unsigned LOSS_COUNT_W  = 8;
    localparam int unsigned RETRY_COUNT_W = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
module sync_ff2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vga_clk_sequencer.sv
// Reference-clock-domain sequencer: resets the pixel PLL, qualifies lock and
// releases the pixel-domain reset, retrying and faulting on lock timeout.
module vga_clk_sequencer
    import vga_clk_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     clear_fault_i,
    input  logic                     pll_locked_i,
    output logic                     pll_resetb_o,
    output logic                     pix_rst_n_o,
    output logic                     ready_o,
    output logic                     fault_o,
    output logic [RETRY_COUNT_W-1:0] retry_count_o,
    output logic [LOSS_COUNT_W-1:0]  lock_loss_count_o
);

    localparam int unsigned CNT_MAX = max3(PLL_RESET_CYCLES, LOCK_STABLE_CYCLES,
                                           LOCK_TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_COUNT_W-1:0] RETRY_LIMIT = RETRY_COUNT_W'(MAX_RETRIES);

    vga_clk_state_t          state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [RETRY_COUNT_W-1:0] retry_q;
    logic [RETRY_COUNT_W-1:0] retry_d;
    logic [LOSS_COUNT_W-1:0] loss_q;
    logic                    pll_resetb_q;
    logic                    pix_rst_n_q;
    logic                    ready_q;
    logic                    fault_q;
    logic                    lock_s;

    sync_ff2 #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked_i),
        .q_o   (lock_s)
    );

    assign retry_d = retry_q + RETRY_COUNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_resetb_q <= 1'b0;
            pix_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!enable_i && state_q != ST_FAULT) begin
                state_q      <= ST_OFF;
                cnt_q        <= '0;
                pll_resetb_q <= 1'b0;
                pix_rst_n_q  <= 1'b0;
                ready_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_OFF: begin
                        state_q <= ST_PLL_RESET;
                        cnt_q   <= '0;
                        retry_q <= '0;
                    end
                    ST_PLL_RESET: begin
                        if (cnt_q == RST_LAST) begin
                            state_q      <= ST_WAIT_LOCK;
                            cnt_q        <= '0;
                            pll_resetb_q <= 1'b1;
                        end
                    end
                    ST_WAIT_LOCK: begin
                        // The qualifying lock sample is already sample 1 of the
                        // stable run, so STABLE starts with one sample counted.
                        if (lock_s) begin
                            cnt_q <= CNT_W'(1);
                            if (LOCK_STABLE_CYCLES == 1) begin
                                state_q     <= ST_RUN;
                                pix_rst_n_q <= 1'b1;
                                ready_q     <= 1'b1;
                            end else begin
                                state_q <= ST_STABLE;
                            end
                        end else if (cnt_q == TO_LAST) begin
                            retry_q      <= retry_d;
                            cnt_q        <= '0;
                            pll_resetb_q <= 1'b0;
                            if (retry_d == RETRY_LIMIT) begin
                                state_q <= ST_FAULT;
                                fault_q <= 1'b1;
                            end else begin
                                state_q <= ST_PLL_RESET;
                            end
                        end
                    end
                    ST_STABLE: begin
                        if (!lock_s) begin
                            state_q <= ST_WAIT_LOCK;
                            cnt_q   <= '0;
                        end else if (cnt_q == STB_LAST) begin
                            state_q     <= ST_RUN;
                            cnt_q       <= '0;
                            pix_rst_n_q <= 1'b1;
                            ready_q     <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!lock_s) begin
                            state_q     <= ST_WAIT_LOCK;
                            cnt_q       <= '0;
                            pix_rst_n_q <= 1'b0;
                            ready_q     <= 1'b0;
                            if (loss_q != '1) begin
                                loss_q <= loss_q + LOSS_COUNT_W'(1);
                            end
                        end
                    end
                    ST_FAULT: begin
                        if (clear_fault_i) begin
                            state_q <= ST_OFF;
                            cnt_q   <= '0;
                            fault_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_OFF;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign pll_resetb_o      = pll_resetb_q;
    assign pix_rst_n_o       = pix_rst_n_q;
    assign ready_o           = ready_q;
    assign fault_o           = fault_q;
    assign retry_count_o     = retry_q;
    assign lock_loss_count_o = loss_q;

endmodule
